// File: rtl/debounce_bit.sv
// One input bit: 2-flop synchronizer, then a stability counter that moves the
// synchronized value to level only after Stable_Count consecutive enabled samples.
module debounce_bit #(
  parameter int Stable_Count = 4,
  parameter int Count_Bits   = 16
) (
  input  logic clk,
  input  logic sres,
  input  logic ld_en,
  input  logic raw,
  output logic level,
  output logic bouncing
);

  localparam logic [Count_Bits-1:0] LAST = Count_Bits'(Stable_Count - 1);

  logic                  sync1, sync2;
  logic [Count_Bits-1:0] cnt;

  always_ff @(posedge clk) begin
    if (sres) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      level <= 1'b0;
      cnt   <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      // Agreement with the current level discards any partial qualification.
      if (sync2 == level) begin
        cnt <= '0;
      end else if (ld_en) begin
        if (cnt == LAST) begin
          level <= sync2;
          cnt   <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

  assign bouncing = (cnt != '0);

endmodule

// File: rtl/debounce_variable_width.sv
// Width independent debouncers; Level_Out feeds the both-edge pulse detector and
// ld_en is a shared prescaler tick that scales the qualification window.
module debounce_variable_width #(
  parameter int Width        = 1,
  parameter int Stable_Count = 4,
  parameter int Count_Bits   = 16
) (
  input  logic             clk,
  input  logic             sres,
  input  logic             ld_en,
  input  logic [Width-1:0] Raw_In,
  output logic [Width-1:0] Level_Out,
  output logic [Width-1:0] Bouncing
);

  initial begin
    assert (Stable_Count >= 1 &&
            longint'(Stable_Count) <= ((longint'(1) << Count_Bits) - 1))
      else $error("Stable_Count out of range for Count_Bits");
  end

  for (genvar i = 0; i < Width; i++) begin : g_bit
    debounce_bit #(
      .Stable_Count(Stable_Count),
      .Count_Bits  (Count_Bits)
    ) u_bit (
      .clk     (clk),
      .sres    (sres),
      .ld_en   (ld_en),
      .raw     (Raw_In[i]),
      .level   (Level_Out[i]),
      .bouncing(Bouncing[i])
    );
  end

endmodule
